// File: rtl/seq_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_filter_pkg
//  Purpose  : Shared coefficients, derived constants and FSM state type for
//             the second-order filter and its inverse.
//  Revision : 1.0  initial release
// ============================================================================
package seq_filter_pkg;

  localparam logic [31:0] A_DEF = 32'd2;
  localparam logic [31:0] B_DEF = 32'd3;
  localparam int          W_DEF = 32;

  // Coefficient product, wrapping mod 2^32 like the datapath.
  function automatic logic [31:0] coef_mul(input logic [31:0] p, input logic [31:0] q);
    return p * q;
  endfunction

  localparam logic [31:0] AA = coef_mul(A_DEF, A_DEF);
  localparam logic [31:0] AB = coef_mul(A_DEF, B_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/div_seq_u.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_u
//  Purpose  : Unsigned W-bit restoring divider, one quotient bit per cycle.
//             start loads operands; done pulses one cycle after the last bit.
//             abort drops any division in flight.
//  Revision : 1.0  initial release
// ============================================================================
module div_seq_u #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dsr_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  // Partial remainder shifted left with the next dividend bit, and the trial
  // subtraction; a set top bit means the subtraction went negative.
  logic [W:0] shifted;
  logic [W:0] trial;
  assign shifted = {rem_q, quo_q[W-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  // Operand load, per-bit iteration and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dsr_q  <= divisor_i;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        if (trial[W]) begin
          rem_q <= shifted[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end else begin
          rem_q <= trial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule
`default_nettype wire

// File: rtl/sequence_inverse.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_inverse
//  Purpose  : Recovers x[n] from y[n] = A^2*y[n-2] + A*B*x[n-1] + B*x[n] as
//             x[n] = (y[n] - A^2*y[n-2] - A*B*x[n-1]) / B, using a sequential
//             divider behind a valid/ready handshake on both sides.
//  Options  : SEQ_INV_CLEAR_EN adds a synchronous 'clear' input that flushes
//             the in-flight sample and the history.
//  Revision : 1.0  initial release
// ============================================================================
module sequence_inverse
  import seq_filter_pkg::*;
#(
  parameter logic [31:0] A = A_DEF,
  parameter logic [31:0] B = B_DEF,
  parameter int          W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
`ifdef SEQ_INV_CLEAR_EN
  input  logic         clear,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic         inexact
);

  localparam logic [W-1:0] C_AA    = W'(coef_mul(A, A));
  localparam logic [W-1:0] C_AB    = W'(coef_mul(A, B));
  localparam logic [W-1:0] C_B     = W'(B);
  localparam logic         C_B_NEG = C_B[W-1];
  localparam logic [W-1:0] C_B_MAG = C_B_NEG ? (-C_B) : C_B;

  if (B == 32'd0) begin : g_b_zero_check
    $error("sequence_inverse: coefficient B must be nonzero");
  end

  logic w_clear;
`ifdef SEQ_INV_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  seq_state_e   state_q, state_d;
  logic         in_ready_q;
  logic [W-1:0] y_lat_q;
  logic [W-1:0] y1_q, y2_q, x1_q;
  logic [W-1:0] num_q;
  logic [W-1:0] x_out_q;
  logic         inexact_q;

  logic         accept;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic [W-1:0] num_d;
  logic [W-1:0] num_mag;
  logic         res_neg;
  logic [W-1:0] x_res;

  assign in_ready = in_ready_q & ~w_clear;
  assign accept   = in_valid & in_ready;

  // Numerator from the latched sample and history; all terms wrap mod 2^W.
  assign num_d   = y_lat_q - (C_AA * y2_q) - (C_AB * x1_q);
  // Magnitude of -2^(W-1) is 2^(W-1) when read as unsigned, which is intended.
  assign num_mag = num_d[W-1] ? (-num_d) : num_d;
  assign res_neg = num_q[W-1] ^ C_B_NEG;
  assign x_res   = res_neg ? (-div_quot) : div_quot;

  div_seq_u #(.W(W)) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .abort_i    (w_clear),
    .dividend_i (num_mag),
    .divisor_i  (C_B_MAG),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // Next-state logic; the divider is launched on the CALC cycle.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        div_start = 1'b1;
        state_d   = DIV;
      end
      DIV:  if (div_done && !div_busy) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (w_clear) begin
      state_d   = IDLE;
      div_start = 1'b0;
    end
  end

  // State register; in_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  // Datapath: sample latch, numerator, result capture and history shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_lat_q   <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      x1_q      <= '0;
      num_q     <= '0;
      x_out_q   <= '0;
      inexact_q <= 1'b0;
    end else if (w_clear) begin
      y1_q      <= '0;
      y2_q      <= '0;
      x1_q      <= '0;
      inexact_q <= 1'b0;
    end else begin
      if (accept) y_lat_q <= y_in;
      if (state_q == CALC) num_q <= num_d;
      if (state_q == DIV && div_done) begin
        x_out_q   <= x_res;
        inexact_q <= (div_rem != '0);
      end
      // History only advances once the consumer has taken the result.
      if (state_q == DONE && out_ready) begin
        y2_q <= y1_q;
        y1_q <= y_lat_q;
        x1_q <= x_out_q;
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign x_out     = x_out_q;
  assign inexact   = inexact_q;

endmodule
`default_nettype wire
